// File: rtl/risc_v_mike_imem_loader.sv
// Instruction-memory loader: turns a byte stream into little-endian 32-bit
// words and writes them into the .text region with one-cycle strobes.
// Stream format: count[7:0], count[15:8], then 4*count payload bytes,
// least-significant byte of each word first.
// The core is held for the whole load. load_done pulses once the image is
// written. load_err latches an oversize header.
module risc_v_mike_imem_loader #(
  parameter int unsigned DATA_MEM_DEPTH = 1024,
  parameter logic [31:0] TEXT_BASE      = 32'h0040_0000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_wr_en,
  output logic [31:0]      imem_wr_addr,
  output logic [31:0]      imem_wr_data,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, PAYLOAD, WRITE, DONE, ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_idx_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      shreg_q;
  logic [CNT_W-1:0] hdr_cnt;
  logic             acc;
  logic             hdr_over;
  logic             last_word;

  // A restart pulse closes the byte port for that cycle.
  assign byte_ready = (state_q == HDR_LO || state_q == HDR_HI || state_q == PAYLOAD) && !load_start;
  assign acc        = byte_valid && byte_ready;
  assign hdr_cnt    = CNT_W'({byte_data, count_q[7:0]});
  assign hdr_over   = 32'(hdr_cnt) > DATA_MEM_DEPTH;
  assign last_word  = (word_idx_q + CNT_W'(1)) == count_q;

  assign imem_wr_en   = (state_q == WRITE);
  // Address and data are forced to zero outside the strobe. This keeps the bus quiet while idle.
  assign imem_wr_addr = imem_wr_en ? TEXT_BASE + 32'({word_idx_q, 2'b00}) : 32'h0;
  assign imem_wr_data = imem_wr_en ? shreg_q : 32'h0;
  assign core_hold    = (state_q != IDLE);
  assign load_done    = (state_q == DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. load_start overrides every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      HDR_LO:  if (acc) state_d = HDR_HI;
      HDR_HI:  if (acc) begin
                 if (hdr_cnt == '0)  state_d = DONE;
                 else if (hdr_over)  state_d = ERR;
                 else                state_d = PAYLOAD;
               end
      PAYLOAD: if (acc && byte_cnt_q == 2'd3) state_d = WRITE;
      WRITE:   state_d = last_word ? DONE : PAYLOAD;
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (load_start) state_d = HDR_LO;
  end

  // Datapath: header capture, byte assembly, word counters, sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      word_idx_q   <= '0;
      words_loaded <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      load_err     <= 1'b0;
    end else if (load_start) begin
      word_idx_q   <= '0;
      words_loaded <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      load_err     <= 1'b0;
    end else begin
      unique case (state_q)
        HDR_LO:  if (acc) count_q <= CNT_W'(byte_data);
        HDR_HI:  if (acc) begin
                   count_q <= hdr_cnt;
                   if (hdr_cnt != '0 && hdr_over) load_err <= 1'b1;
                 end
        // Shift right so the first byte received ends up in bits [7:0].
        PAYLOAD: if (acc) begin
                   shreg_q    <= {byte_data, shreg_q[31:8]};
                   byte_cnt_q <= byte_cnt_q + 2'd1;
                 end
        WRITE:   begin
                   word_idx_q   <= word_idx_q + CNT_W'(1);
                   words_loaded <= words_loaded + CNT_W'(1);
                 end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_imem_loader.sv
// Scoreboard bench for the imem loader. Stimulus pushes the expected writes
// and done events. A negedge monitor pops and compares them.
module tb_risc_v_mike_imem_loader;
  localparam logic [31:0] TB_BASE = 32'h0040_0000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        load_start = 1'b0, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_wr_en, core_hold, load_done, load_err;
  logic [31:0] imem_wr_addr, imem_wr_data;
  logic [15:0] words_loaded;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_addr_q[$], exp_data_q[$];
  int          exp_done_q[$];

  risc_v_mike_imem_loader #(.DATA_MEM_DEPTH(1024), .TEXT_BASE(TB_BASE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe and every done pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (imem_wr_en) begin
        chk("ready_in_write", 32'(byte_ready), 32'd0);
        if (exp_addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: addr %h data %h, expected no write", imem_wr_addr, imem_wr_data);
        end else begin
          chk("wr_addr", imem_wr_addr, exp_addr_q.pop_front());
          chk("wr_data", imem_wr_data, exp_data_q.pop_front());
        end
      end
      if (load_done) begin
        chk("hold_at_done", 32'(core_hold), 32'd1);
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: words_loaded %0d, expected no done", words_loaded);
        end else begin
          chk("words_at_done", 32'(words_loaded), 32'(exp_done_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start();
    load_start = 1'b1; tick(1); load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    while (!byte_ready && n < 40) begin @(negedge clk); n++; end
    if (!byte_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_accept_timeout: byte_ready 0, expected 1");
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    tick(gap);
  endtask

  // Reference: word k lands at TEXT_BASE + 4*k. Its value is sum(byte_i << 8*i).
  task automatic send_word(input logic [31:0] w, input int idx, input int maxgap);
    logic [31:0] v;
    v = w;
    exp_addr_q.push_back(TB_BASE + 32'(4 * idx));
    exp_data_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      send(v[7:0], $urandom_range(0, maxgap));
      v = v >> 8;
    end
  endtask

  task automatic run_image(input int cnt, input int maxgap);
    logic [15:0] c;
    c = 16'(cnt);
    exp_done_q.push_back(cnt);
    send(c[7:0], 0);
    send(c[15:8], 0);
    for (int k = 0; k < cnt; k++) send_word($urandom, k, maxgap);
    tick(4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  t1 [10];
    logic [15:0] ec;
    t1 = '{8'h02, 8'h00, 8'h17, 8'h04, 8'hc1, 8'h0f, 8'h93, 8'h04, 8'h44, 8'h02};

    // Reset state
    #3;
    chk("rst_ready", 32'(byte_ready), 0); chk("rst_wr_en", 32'(imem_wr_en), 0);
    chk("rst_hold", 32'(core_hold), 0);   chk("rst_done", 32'(load_done), 0);
    chk("rst_err", 32'(load_err), 0);     chk("rst_words", 32'(words_loaded), 0);
    chk("rst_addr", imem_wr_addr, 0);
    @(posedge clk); #1; rst = 1'b1; tick(2);

    // 1: two-word image from the example stream
    start();
    chk("hold_after_start", 32'(core_hold), 1);
    exp_done_q.push_back(2);
    exp_addr_q.push_back(TB_BASE);     exp_data_q.push_back(32'h0fc10417);
    exp_addr_q.push_back(TB_BASE + 4); exp_data_q.push_back(32'h02440493);
    for (int i = 0; i < 10; i++) send(t1[i], 0);
    @(negedge clk); chk("t1_strobe_latency", 32'(imem_wr_en), 1);
    @(negedge clk); chk("t1_done", 32'(load_done), 1);
    chk("t1_hold_done", 32'(core_hold), 1); chk("t1_words", 32'(words_loaded), 2);
    @(negedge clk); chk("t1_hold_idle", 32'(core_hold), 0); chk("t1_done_gone", 32'(load_done), 0);
    @(posedge clk); #1;

    // 2: empty image
    start();
    exp_done_q.push_back(0);
    send(8'h00, 0); send(8'h00, 0);
    @(negedge clk); chk("t2_done", 32'(load_done), 1); chk("t2_words", 32'(words_loaded), 0);
    @(posedge clk); #1; tick(2);

    // 3: oversize header 1025
    start();
    send(8'h01, 0); send(8'h04, 0);
    @(negedge clk);
    chk("t3_err", 32'(load_err), 1); chk("t3_hold", 32'(core_hold), 1);
    chk("t3_ready", 32'(byte_ready), 0);
    @(posedge clk); #1;
    byte_valid = 1'b1; byte_data = 8'h55; tick(3);
    chk("t3_ignore_bytes", 32'(byte_ready), 0);
    byte_valid = 1'b0;
    start();
    @(negedge clk); chk("t3_err_cleared", 32'(load_err), 0);
    @(posedge clk); #1;

    // 4: count=1 with 3-cycle gaps (load already started above)
    exp_done_q.push_back(1);
    exp_addr_q.push_back(TB_BASE); exp_data_q.push_back(32'hdeadbeef);
    send(8'h01, 3); send(8'h00, 3);
    send(8'hef, 3); send(8'hbe, 3); send(8'had, 3); send(8'hde, 0);
    @(negedge clk);
    chk("t4_strobe", 32'(imem_wr_en), 1); chk("t4_ready_write", 32'(byte_ready), 0);
    @(posedge clk); #1; tick(3);

    // 5: restart mid-word
    start();
    send(8'h03, 0); send(8'h00, 0);
    send_word(32'h11223344, 0, 0);
    send(8'haa, 0); send(8'hbb, 0);
    start();
    @(negedge clk); chk("t5_words_cleared", 32'(words_loaded), 0);
    @(posedge clk); #1;
    run_image(1, 1);
    chk("t5_words", 32'(words_loaded), 1);

    // 6: async reset mid-payload
    start();
    send(8'h02, 0); send(8'h00, 0); send(8'h12, 0); send(8'h34, 0);
    #3; rst = 1'b0; #1;
    chk("t6_hold", 32'(core_hold), 0); chk("t6_ready", 32'(byte_ready), 0);
    chk("t6_words", 32'(words_loaded), 0); chk("t6_wr_en", 32'(imem_wr_en), 0);
    chk("t6_data", imem_wr_data, 0);
    tick(2); rst = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h56; tick(6);
    chk("t6_idle_ready", 32'(byte_ready), 0); chk("t6_idle_hold", 32'(core_hold), 0);
    byte_valid = 1'b0; tick(1);

    // Random images
    for (int it = 0; it < 10; it++) begin
      start();
      run_image($urandom_range(1, 6), $urandom_range(0, 2));
    end

    // Random oversize header
    ec = 16'($urandom_range(1025, 65535));
    start();
    send(ec[7:0], 0); send(ec[15:8], 0);
    @(negedge clk); chk("rand_err", 32'(load_err), 1);
    @(posedge clk); #1;
    start();
    run_image(2, 0);

    tick(10);
    chk("pending_writes", 32'(exp_addr_q.size()), 0);
    chk("pending_done", 32'(exp_done_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
